rawr_wr_burst: RTL and testbench

//  Per-channel write-burst generator upstream of the write-request arbiter: one instance per CHANNEL_NUM input.

---
 rtl/rawr_wr_burst.sv | 145 ++++++++++++++
 tb/tb_rawr_wr_burst.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rawr_wr_burst.sv
// Per-channel RAWR write-burst generator: buffers a valid/ready beat stream and
// issues bursts of up to BURST_LEN beats onto a wrapping address ring.
module rawr_wr_burst #(
  parameter int                        APP_DATA_WIDTH = 128,
  parameter int                        APP_ADDR_WIDTH = 28,
  parameter int                        BURST_LEN      = 64,
  parameter int                        FIFO_AW        = 8,
  parameter int                        ADDR_STEP      = 8,
  parameter logic [APP_ADDR_WIDTH-1:0] ADDR_BASE      = '0,
  parameter logic [APP_ADDR_WIDTH-1:0] ADDR_SPAN      = 28'h100000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [APP_DATA_WIDTH-1:0]     s_data,
  input  logic                          flush,
  output logic                          busy,
  output logic                          err,
  output logic                          wr_req,
  output logic [APP_ADDR_WIDTH-1:0]     wr_addr,
  output logic [9:0]                    wr_num,
  output logic [APP_DATA_WIDTH-1:0]     wr_data,
  output logic [APP_DATA_WIDTH/8-1:0]   wr_mask,
  input  logic                          wr_grant,
  input  logic                          wr_finish
);

  localparam int AW1   = APP_ADDR_WIDTH + 1;
  localparam int CW    = FIFO_AW + 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [AW1-1:0] RING_END = {1'b0, ADDR_BASE} + {1'b0, ADDR_SPAN};

  typedef enum logic [1:0] {IDLE, REQ, WAIT_FIN, GAP} state_t;

  state_t                      state_reg;
  logic [APP_DATA_WIDTH-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]               cnt_reg, cnt_next;
  logic [APP_ADDR_WIDTH-1:0]   cur_addr_reg, adv_addr;
  logic [9:0]                  beat_cnt_reg, beat_cnt_inc, adv_beats;
  logic                        flush_pend_reg, gap_reg;
  logic                        push, pop, start, grant_err, fin_err;
  logic [AW1-1:0]              to_end, burst_take, adv_sum;

  always_comb begin
    push         = s_valid & s_ready;
    // Beats are only consumed while a request is open and data is present.
    pop          = wr_grant & (state_reg == REQ) & (cnt_reg != '0);
    grant_err    = wr_grant & ~pop;
    cnt_next     = cnt_reg + CW'(push) - CW'(pop);
    beat_cnt_inc = beat_cnt_reg + 10'(pop);
    start        = (state_reg == IDLE) &&
                   ((AW1'(cnt_reg) >= AW1'(BURST_LEN)) || (flush_pend_reg && cnt_reg != '0));
    to_end       = (RING_END - {1'b0, cur_addr_reg}) / AW1'(ADDR_STEP);
    burst_take   = AW1'(BURST_LEN);
    if (AW1'(cnt_reg) < burst_take) burst_take = AW1'(cnt_reg);
    if (to_end < burst_take)        burst_take = to_end;
    fin_err      = wr_finish & ((state_reg == IDLE) | (state_reg == GAP) |
                                ((state_reg == REQ) & (beat_cnt_inc != wr_num)));
    // An early finish advances the ring only by the beats actually granted.
    adv_beats    = (state_reg == REQ) ? beat_cnt_inc : wr_num;
    adv_sum      = {1'b0, cur_addr_reg} + AW1'(adv_beats) * AW1'(ADDR_STEP);
    adv_addr     = (adv_sum == RING_END) ? ADDR_BASE : adv_sum[APP_ADDR_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= s_data;
  end

  assign wr_data = mem[rd_ptr_reg];
  assign wr_mask = '0;
  assign busy    = (state_reg != IDLE) || (cnt_reg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
      cnt_reg <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      s_ready        <= 1'b0;
      err            <= 1'b0;
      wr_req         <= 1'b0;
      wr_addr        <= ADDR_BASE;
      wr_num         <= '0;
      cur_addr_reg   <= ADDR_BASE;
      beat_cnt_reg   <= '0;
      flush_pend_reg <= 1'b0;
      gap_reg        <= 1'b0;
    end else begin
      s_ready <= (cnt_next < CW'(DEPTH));
      err     <= err | grant_err | fin_err;
      if (flush)
        flush_pend_reg <= 1'b1;
      else if (state_reg == IDLE && cnt_reg == '0)
        flush_pend_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start) begin
            wr_req       <= 1'b1;
            wr_addr      <= cur_addr_reg;
            wr_num       <= burst_take[9:0];
            beat_cnt_reg <= '0;
            state_reg    <= REQ;
          end
        end
        REQ: begin
          beat_cnt_reg <= beat_cnt_inc;
          if (wr_finish) begin
            wr_req       <= 1'b0;
            cur_addr_reg <= adv_addr;
            gap_reg      <= 1'b0;
            state_reg    <= GAP;
          end else if (beat_cnt_inc == wr_num) begin
            state_reg <= WAIT_FIN;
          end
        end
        WAIT_FIN: begin
          if (wr_finish) begin
            wr_req       <= 1'b0;
            cur_addr_reg <= adv_addr;
            gap_reg      <= 1'b0;
            state_reg    <= GAP;
          end
        end
        default: begin
          // Two low cycles so the arbiter's edge detector sees the fall.
          if (gap_reg) state_reg <= IDLE;
          else         gap_reg   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rawr_wr_burst.sv
// Randomized bench for rawr_wr_burst: a queue-based reference model predicts burst
// address/length, beat data order, ready and error behaviour.
module tb_rawr_wr_burst;
  localparam int DW    = 128;
  localparam int AW    = 28;
  localparam int BL    = 64;
  localparam int FAW   = 8;
  localparam int DEPTH = 1 << FAW;
  localparam int STEP  = 8;
  localparam int BASE  = 0;
  localparam int SPAN  = 'h1000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            s_valid, s_ready, flush, busy, err;
  logic [DW-1:0]   s_data, wr_data;
  logic            wr_req, wr_grant, wr_finish;
  logic [AW-1:0]   wr_addr;
  logic [9:0]      wr_num;
  logic [DW/8-1:0] wr_mask;

  rawr_wr_burst #(
    .APP_DATA_WIDTH(DW), .APP_ADDR_WIDTH(AW), .BURST_LEN(BL), .FIFO_AW(FAW),
    .ADDR_STEP(STEP), .ADDR_BASE(AW'(BASE)), .ADDR_SPAN(AW'(SPAN))
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .flush(flush), .busy(busy), .err(err), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_num(wr_num), .wr_data(wr_data), .wr_mask(wr_mask), .wr_grant(wr_grant),
    .wr_finish(wr_finish)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state, advanced once per cycle on the falling edge.
  logic [DW-1:0] q[$];
  int  cyc = 0, sz_prev = 0, last_fin = -100;
  int  m_addr = BASE, m_num = 0, m_granted = 0;
  bit  m_active = 0, err_exp = 0, prev_req = 0, fell_chk = 0;
  int  txn_cnt = 0, split_cnt = 0, full_seen = 0;

  always @(negedge clk) begin
    int sz, to_end, exp_num;
    if (!rst_n) begin
      q.delete();
      m_addr = BASE; m_active = 0; m_granted = 0; err_exp = 0;
      prev_req = 0; fell_chk = 0; sz_prev = 0; last_fin = -100;
    end else begin
      cyc++;
      sz = q.size();
      check_eq("s_ready", DW'(s_ready), DW'(sz < DEPTH));
      if (!s_ready) full_seen++;
      check_eq("err", DW'(err), DW'(err_exp));
      if (fell_chk) check_eq("req_fall", DW'(wr_req), DW'(0));
      fell_chk = 0;
      if (wr_req && !prev_req) begin
        to_end  = (BASE + SPAN - m_addr) / STEP;
        exp_num = sz_prev;
        if (BL < exp_num)     exp_num = BL;
        if (to_end < exp_num) exp_num = to_end;
        check_eq("wr_addr", DW'(wr_addr), DW'(m_addr));
        check_eq("wr_num", DW'(wr_num), DW'(exp_num));
        // Finish edge to next rise edge is at least 3 clocks, i.e. 4 sampled cycles apart.
        check_eq("spacing", DW'(cyc - last_fin >= 4), DW'(1));
        if (to_end < BL && exp_num == to_end) split_cnt++;
        m_active = 1; m_num = exp_num; m_granted = 0;
        txn_cnt++;
      end else if (m_active) begin
        check_eq("req_hold", DW'(wr_req), DW'(1));
        check_eq("addr_hold", DW'(wr_addr), DW'(m_addr));
        check_eq("num_hold", DW'(wr_num), DW'(m_num));
      end
      if (wr_grant) begin
        if (m_active && m_granted < m_num && q.size() > 0) begin
          check_eq("wr_data", wr_data, q[0]);
          void'(q.pop_front());
          m_granted++;
        end else begin
          err_exp = 1;
        end
      end
      if (wr_finish) begin
        if (m_active) begin
          if (m_granted < m_num) err_exp = 1;
          m_addr = m_addr + m_granted * STEP;
          if (m_addr == BASE + SPAN) m_addr = BASE;
          m_active = 0; last_fin = cyc; fell_chk = 1;
        end else begin
          err_exp = 1;
        end
      end
      if (s_valid && s_ready) q.push_back(s_data);
      sz_prev  = sz;
      prev_req = wr_req;
    end
  end

  // Slave side of the RAWR handshake.
  int grant_pct = 100, early_fin = 0;
  bit poke_grant = 0;
  initial begin
    bit s_active;
    int s_num, s_granted, s_wait;
    s_active = 0; s_num = 0; s_granted = 0; s_wait = 0;
    wr_grant = 0; wr_finish = 0;
    forever begin
      @(posedge clk); #1;
      wr_grant = 0; wr_finish = 0;
      if (!rst_n) begin
        s_active = 0;
      end else if (!s_active && poke_grant) begin
        wr_grant = 1; poke_grant = 0;
      end else begin
        if (!s_active && wr_req) begin
          s_active = 1; s_num = int'(wr_num); s_granted = 0; s_wait = $urandom_range(2);
        end
        if (s_active) begin
          if (s_granted < s_num && (early_fin == 0 || s_granted < early_fin)) begin
            if ($urandom_range(99) < grant_pct) begin
              wr_grant = 1; s_granted++;
            end
          end else if (s_wait == 0) begin
            wr_finish = 1; s_active = 0;
          end else begin
            s_wait--;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_n(input int n, input bit seq);
    bit acc;
    int tries;
    for (int i = 0; i < n; i++) begin
      s_valid = 1;
      s_data  = seq ? DW'(i) : {$urandom, $urandom, $urandom, $urandom};
      tries   = 0;
      do begin
        @(negedge clk); acc = s_ready;
        @(posedge clk); #1; tries++;
      end while (!acc && tries < 5000);
      if (!acc) begin
        check_eq("push_timeout", DW'(acc), DW'(1));
        break;
      end
    end
    s_valid = 0;
  endtask

  task automatic flush_pulse();
    flush = 1; tick(1); flush = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || wr_req) && k < 5000) begin tick(1); k++; end
    check_eq("idle_timeout", DW'(busy), DW'(0));
  endtask

  task automatic release_reset();
    @(negedge clk); #1 rst_n = 1;
    check_eq("rst_s_ready", DW'(s_ready), DW'(0));
    check_eq("rst_err", DW'(err), DW'(0));
    check_eq("rst_busy", DW'(busy), DW'(0));
    check_eq("rst_wr_addr", DW'(wr_addr), DW'(BASE));
    check_eq("rst_wr_num", DW'(wr_num), DW'(0));
    check_eq("rst_wr_req", DW'(wr_req), DW'(0));
    @(posedge clk); #1;
    check_eq("s_ready_rise", DW'(s_ready), DW'(1));
  endtask

  initial begin
    int t0, k;
    rst_n = 0; s_valid = 0; s_data = '0; flush = 0;
    tick(3);
    check_eq("mask_zero", DW'(wr_mask), DW'(0));
    release_reset();

    // Full burst with sequential data and an always-ready slave.
    t0 = txn_cnt;
    push_n(64, 1);
    wait_idle();
    check_eq("t1_txns", DW'(txn_cnt - t0), DW'(1));

    // Partial burst released by flush; flush must not linger afterwards.
    push_n(10, 1);
    flush_pulse();
    wait_idle();
    check_eq("flush_err", DW'(err), DW'(0));
    t0 = txn_cnt;
    push_n(10, 0);
    tick(40);
    check_eq("no_stale_flush", DW'(txn_cnt), DW'(t0));
    check_eq("busy_resident", DW'(busy), DW'(1));
    flush_pulse();
    wait_idle();

    // Streaming with random grant gaps; crosses the ring end and fills the FIFO.
    grant_pct = 50;
    push_n(600, 0);
    flush_pulse();
    wait_idle();
    check_eq("ring_split_seen", DW'(split_cnt > 0), DW'(1));
    check_eq("fifo_full_seen", DW'(full_seen > 0), DW'(1));

    // Early finish after 5 beats: error, ring advances by 5 beats, data resumes at beat 5.
    grant_pct = 100; early_fin = 5;
    t0 = txn_cnt;
    push_n(64, 1);
    k = 0;
    while (!(txn_cnt > t0 && !m_active) && k < 2000) begin tick(1); k++; end
    check_eq("early_fin_timeout", DW'(k < 2000), DW'(1));
    tick(2);
    check_eq("early_fin_err", DW'(err), DW'(1));
    early_fin = 0;
    flush_pulse();
    wait_idle();

    // Asynchronous reset in the middle of a burst.
    grant_pct = 30;
    push_n(64, 0);
    k = 0;
    while (!(wr_req && m_granted >= 3) && k < 2000) begin tick(1); k++; end
    check_eq("midburst_timeout", DW'(k < 2000), DW'(1));
    #2 rst_n = 0;
    #1 check_eq("async_req_drop", DW'(wr_req), DW'(0));
    tick(2);
    release_reset();

    // Fresh burst starts at the ring base; a stray grant in IDLE raises err.
    grant_pct = 100;
    push_n(64, 1);
    wait_idle();
    check_eq("clean_err", DW'(err), DW'(0));
    poke_grant = 1;
    tick(3);
    check_eq("idle_grant_err", DW'(err), DW'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
